// File: rtl/fp_minmax_reduce_pkg.sv
// Shared types and constants for the streaming FMIN/FMAX reduction engine.
package fp_minmax_reduce_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned FLAG_W = 5;
  localparam int unsigned FMT_W  = 2;

  localparam logic [FMT_W-1:0]  FMT_SINGLE = 2'd0;
  localparam logic [DATA_W-1:0] QNAN_D     = 64'h7ff8_0000_0000_0000;
  localparam logic [DATA_W-1:0] QNAN_S     = 64'h0000_0000_7fc0_0000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [FMT_W-1:0] fmt;
    logic             op;
  } fp_minmax_red_in_type;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [FLAG_W-1:0] flags;
  } fp_minmax_red_out_type;

  typedef struct packed {
    logic              sign;
    logic              nan;
    logic              snan;
    logic [DATA_W-1:0] mag;
  } fp_class_t;

  // Identity element of the reduction; reserved formats behave as double.
  function automatic logic [DATA_W-1:0] canon_nan(input logic [FMT_W-1:0] fmt);
    return (fmt == FMT_SINGLE) ? QNAN_S : QNAN_D;
  endfunction

endpackage

// File: rtl/fp_minmax_reduce_if.sv
// Command / operand / result handshake bundle for fp_minmax_reduce.
interface fp_minmax_reduce_if
  import fp_minmax_reduce_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [FMT_W-1:0]      cmd_fmt;
  logic                  cmd_op;
  logic [CNT_W-1:0]      cmd_count;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*64-1:0]   in_data;
  logic [LANES-1:0]      in_mask;
  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_W-1:0]     res_data;
  logic [FLAG_W-1:0]     res_flags;

  modport master (
    output cmd_valid, cmd_fmt, cmd_op, cmd_count, in_valid, in_data, in_mask, res_ready,
    input  cmd_ready, in_ready, res_valid, res_data, res_flags
  );

  modport slave (
    input  cmd_valid, cmd_fmt, cmd_op, cmd_count, in_valid, in_data, in_mask, res_ready,
    output cmd_ready, in_ready, res_valid, res_data, res_flags
  );

endinterface

// File: rtl/fp_minmax_reduce_cell.sv
// Combinational two-operand fmin/fmax with RISC-V NaN and signed-zero rules.
module fp_minmax_reduce_cell
  import fp_minmax_reduce_pkg::*;
(
  input  logic [FMT_W-1:0]  fmt,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              nv
);

  function automatic fp_class_t classify(input logic [DATA_W-1:0] x, input logic single);
    fp_class_t c;
    if (single) begin
      c.sign = x[31];
      c.nan  = (&x[30:23]) & (|x[22:0]);
      c.snan = c.nan & ~x[22];
      c.mag  = {33'b0, x[30:0]};
    end else begin
      c.sign = x[63];
      c.nan  = (&x[62:52]) & (|x[51:0]);
      c.snan = c.nan & ~x[51];
      c.mag  = {1'b0, x[62:0]};
    end
    return c;
  endfunction

  logic              single;
  logic [DATA_W-1:0] an, bn;
  fp_class_t         ca, cb;
  logic              a_lt_b;
  logic              pick_a;

  always_comb begin
    single = (fmt == FMT_SINGLE);
    an     = single ? {32'b0, a[31:0]} : a;
    bn     = single ? {32'b0, b[31:0]} : b;
    ca     = classify(a, single);
    cb     = classify(b, single);
    nv     = ca.snan | cb.snan;
    // Total order on non-NaN values: sign first, then magnitude inverted for negatives.
    if (ca.sign != cb.sign) a_lt_b = ca.sign;
    else if (ca.sign)       a_lt_b = (ca.mag > cb.mag);
    else                    a_lt_b = (ca.mag < cb.mag);
    pick_a = op ? ~a_lt_b : a_lt_b;
    if (ca.nan && cb.nan) y = canon_nan(fmt);
    else if (ca.nan)      y = bn;
    else if (cb.nan)      y = an;
    else                  y = pick_a ? an : bn;
  end

endmodule

// File: rtl/fp_minmax_reduce.sv
// Streaming FMIN/FMAX reduction: lane tree per beat, registered accumulator across beats.
module fp_minmax_reduce
  import fp_minmax_reduce_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  fp_minmax_reduce_if.slave  bus
);

  state_t                state_q, state_d;
  logic                  cmd_ready_q, in_ready_q, res_valid_q;
  logic                  cmd_ready_d, in_ready_d, res_valid_d;
  logic [CNT_W-1:0]      cnt_q;
  fp_minmax_red_in_type  cmd_q;
  fp_minmax_red_out_type res_q;

  logic                  cmd_acc, beat_acc, res_acc;
  logic [DATA_W-1:0]     node [1:2*LANES-1];
  logic [LANES-1:0]      node_nv;
  logic [DATA_W-1:0]     acc_nx;
  logic                  merge_nv;

  assign cmd_acc  = bus.cmd_valid & cmd_ready_q;
  assign beat_acc = bus.in_valid & in_ready_q;
  assign res_acc  = res_valid_q & bus.res_ready;

  // Leaves: masked lanes become the identity element.
  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign node[LANES+i] = bus.in_mask[i] ? bus.in_data[64*i +: 64] : canon_nan(cmd_q.fmt);
  end

  assign node_nv[0] = 1'b0;
  for (genvar k = 1; k < LANES; k++) begin : g_tree
    fp_minmax_reduce_cell u_cell (
      .fmt (cmd_q.fmt),
      .op  (cmd_q.op),
      .a   (node[2*k]),
      .b   (node[2*k+1]),
      .y   (node[k]),
      .nv  (node_nv[k])
    );
  end

  fp_minmax_reduce_cell u_merge (
    .fmt (cmd_q.fmt),
    .op  (cmd_q.op),
    .a   (res_q.data),
    .b   (node[1]),
    .y   (acc_nx),
    .nv  (merge_nv)
  );

  // State register; handshake outputs are registered from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_acc) state_d = (bus.cmd_count == '0) ? DONE : RUN;
      RUN:  if (beat_acc && cnt_q == CNT_W'(1)) state_d = DONE;
      DONE: if (res_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    in_ready_d  = (state_d == RUN);
    res_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      cmd_q <= '0;
      res_q <= '0;
    end else if (cmd_acc) begin
      cnt_q       <= bus.cmd_count;
      cmd_q.fmt   <= bus.cmd_fmt;
      cmd_q.op    <= bus.cmd_op;
      res_q.data  <= canon_nan(bus.cmd_fmt);
      res_q.flags <= '0;
    end else if (beat_acc) begin
      cnt_q       <= cnt_q - CNT_W'(1);
      res_q.data  <= acc_nx;
      res_q.flags <= {res_q.flags[FLAG_W-1] | merge_nv | (|node_nv), 4'b0};
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_q.data;
  assign bus.res_flags = res_q.flags;

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Self-checking bench for fp_minmax_reduce: directed vector table, corner sequences, random vs model.
module tb_fp_minmax_reduce;

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAX_B = 3;
  localparam logic [63:0] T_QNAN_D = 64'h7ff8_0000_0000_0000;
  localparam logic [63:0] T_QNAN_S = 64'h0000_0000_7fc0_0000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fp_minmax_reduce_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();

  fp_minmax_reduce #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string                               name;
    logic [1:0]                          fmt;
    logic                                op;
    int                                  count;
    logic [MAX_B-1:0][LANES*64-1:0]      data;
    logic [MAX_B-1:0][LANES-1:0]         mask;
    logic [63:0]                         exp_d;
    logic [4:0]                          exp_f;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [LANES*64-1:0] lanes_d(input logic [63:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  // Upper halves carry junk that a single-precision reduction must ignore.
  function automatic logic [LANES*64-1:0] lanes_s(input logic [31:0] a0, a1, a2, a3);
    return {32'hdeadbeef, a3, 32'hdeadbeef, a2, 32'hdeadbeef, a1, 32'hdeadbeef, a0};
  endfunction

  task automatic send_cmd(input logic [1:0] fmt, input logic op, input int count);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_fmt   = fmt;
    bus.cmd_op    = op;
    bus.cmd_count = CNT_W'(count);
    while (!bus.cmd_ready && n < 20) begin tick(); n++; end
    check("cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [LANES*64-1:0] data, input logic [LANES-1:0] mask, input int gap);
    int n = 0;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_mask  = mask;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    check("in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after the last accept edge; result must already be valid.
  task automatic get_result(input string tag, input logic [63:0] exp_d, input logic [4:0] exp_f, input int hold);
    int n = 0;
    check({tag, "_latency"}, 64'(bus.res_valid), 64'd1);
    while (!bus.res_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_data"}, bus.res_data, exp_d);
      check({tag, "_hold_cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
      tick();
    end
    check({tag, "_data"}, bus.res_data, exp_d);
    check({tag, "_flags"}, 64'(bus.res_flags), 64'(exp_f));
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_res_valid_drop"}, 64'(bus.res_valid), 64'd0);
    check({tag, "_back_idle"}, 64'(bus.cmd_ready), 64'd1);
  endtask

  // Reference: reduce all participating operands with a signed total-order key.
  function automatic void model(input logic [1:0] fmt, input logic op, input logic [63:0] ops[$],
                                output logic [63:0] res, output logic nv);
    bit          have = 0;
    longint      best_key = 0;
    logic [63:0] best = '0;
    bit          single = (fmt == 2'd0);
    nv = 1'b0;
    foreach (ops[i]) begin
      logic [63:0] x, val, mag;
      bit          nan, sn, sign;
      longint      key;
      x = ops[i];
      if (single) begin
        nan  = (x[30:23] == 8'hff) && (x[22:0] != 0);
        sn   = nan && !x[22];
        sign = x[31];
        mag  = {33'b0, x[30:0]};
        val  = {32'b0, x[31:0]};
      end else begin
        nan  = (x[62:52] == 11'h7ff) && (x[51:0] != 0);
        sn   = nan && !x[51];
        sign = x[63];
        mag  = {1'b0, x[62:0]};
        val  = x;
      end
      key = sign ? (-longint'(mag) - 1) : longint'(mag);
      if (sn) nv = 1'b1;
      if (!nan && (!have || (op ? key > best_key : key < best_key))) begin
        have = 1; best_key = key; best = val;
      end
    end
    res = have ? best : (single ? T_QNAN_S : T_QNAN_D);
  endfunction

  function automatic logic [63:0] rand_operand(input logic [1:0] fmt);
    logic [31:0] s;
    logic [63:0] d, r;
    logic        sg;
    r  = {$urandom(), $urandom()};
    sg = r[63];
    if (fmt == 2'd0) begin
      case ($urandom_range(0, 11))
        0: s = 32'h0000_0000;
        1: s = 32'h8000_0000;
        2: s = 32'h7f80_0000;
        3: s = 32'hff80_0000;
        4: s = {sg, 8'hff, 1'b1, r[21:0]};
        5: s = {sg, 8'hff, 1'b0, r[21:1], 1'b1};
        6: s = 32'h3f80_0000;
        7: s = 32'hbf80_0000;
        default: s = r[31:0];
      endcase
      return {$urandom(), s};
    end
    case ($urandom_range(0, 11))
      0: d = 64'h0;
      1: d = 64'h8000_0000_0000_0000;
      2: d = 64'h7ff0_0000_0000_0000;
      3: d = 64'hfff0_0000_0000_0000;
      4: d = {sg, 11'h7ff, 1'b1, r[50:0]};
      5: d = {sg, 11'h7ff, 1'b0, r[50:1], 1'b1};
      6: d = 64'h3ff0_0000_0000_0000;
      7: d = 64'hbff0_0000_0000_0000;
      default: d = r;
    endcase
    return d;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  vec_t vecs[9];

  initial begin
    logic [63:0] exp_d;
    logic        exp_nv;
    logic [63:0] ops[$];

    vecs[0] = '{"dmax_basic", 2'd1, 1'b1, 1, '0, '0, 64'h400c000000000000, 5'h00};
    vecs[0].data[0] = lanes_d(64'h3ff0000000000000, 64'hc000000000000000, 64'h400c000000000000, 64'h0);
    vecs[0].mask[0] = 4'hF;
    vecs[1] = '{"smin_signed_zero", 2'd0, 1'b0, 2, '0, '0, 64'h0000000080000000, 5'h00};
    vecs[1].data[0] = lanes_s(32'h00000000, 32'h80000000, 32'h3f800000, 32'h40000000);
    vecs[1].data[1] = lanes_s(32'h40a00000, 32'h40c00000, 32'h40e00000, 32'h41000000);
    vecs[1].mask[0] = 4'hF; vecs[1].mask[1] = 4'hF;
    vecs[2] = '{"dmax_snan", 2'd1, 1'b1, 1, '0, '0, 64'h4000000000000000, 5'h10};
    vecs[2].data[0] = lanes_d(64'h7ff4000000000000, 64'h3ff0000000000000, 64'h4000000000000000, 64'hbff0000000000000);
    vecs[2].mask[0] = 4'hF;
    vecs[3] = '{"dmin_count0", 2'd1, 1'b0, 0, '0, '0, 64'h7ff8000000000000, 5'h00};
    vecs[4] = '{"smax_all_nan", 2'd0, 1'b1, 1, '0, '0, 64'h000000007fc00000, 5'h10};
    vecs[4].data[0] = lanes_s(32'h7fa00000, 32'h7fc00001, 32'hffc00000, 32'h7fc00000);
    vecs[4].mask[0] = 4'hF;
    vecs[5] = '{"dmin_negatives", 2'd1, 1'b0, 1, '0, '0, 64'hc00c000000000000, 5'h00};
    vecs[5].data[0] = lanes_d(64'hbff0000000000000, 64'hc000000000000000, 64'hc00c000000000000, 64'h4014000000000000);
    vecs[5].mask[0] = 4'hF;
    vecs[6] = '{"dmax_zeros", 2'd1, 1'b1, 1, '0, '0, 64'h0, 5'h00};
    vecs[6].data[0] = lanes_d(64'h8000000000000000, 64'h0, 64'h8000000000000000, 64'h8000000000000000);
    vecs[6].mask[0] = 4'hF;
    vecs[7] = '{"dmin_masked", 2'd1, 1'b0, 2, '0, '0, 64'h3ff0000000000000, 5'h00};
    vecs[7].data[0] = lanes_d(64'h7ff4000000000000, 64'h0, 64'h0, 64'h0);
    vecs[7].data[1] = lanes_d(64'h3ff0000000000000, 64'hc000000000000000, 64'hc000000000000000, 64'hc000000000000000);
    vecs[7].mask[0] = 4'h0; vecs[7].mask[1] = 4'h1;
    vecs[8] = '{"fmt3_as_double", 2'd3, 1'b0, 1, '0, '0, 64'hfff0000000000000, 5'h00};
    vecs[8].data[0] = lanes_d(64'h7ff0000000000000, 64'hfff0000000000000, 64'h0, 64'h3ff0000000000000);
    vecs[8].mask[0] = 4'hF;

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_fmt = '0; bus.cmd_op = 1'b0; bus.cmd_count = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mask = '0; bus.res_ready = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_res_valid", 64'(bus.res_valid), 64'd0);
    check("rst_res_data", bus.res_data, 64'd0);
    check("rst_res_flags", 64'(bus.res_flags), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    foreach (vecs[i]) begin
      send_cmd(vecs[i].fmt, vecs[i].op, vecs[i].count);
      for (int b = 0; b < vecs[i].count; b++) send_beat(vecs[i].data[b], vecs[i].mask[b], 0);
      get_result(vecs[i].name, vecs[i].exp_d, vecs[i].exp_f, 0);
    end

    // Gappy single max with a partially masked middle beat; extra in_valid must not be taken.
    send_cmd(2'd0, 1'b1, 3);
    send_beat(lanes_s(32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000), 4'hF, 1);
    send_beat(lanes_s(32'h40a00000, 32'h447a0000, 32'h447a0000, 32'h447a0000), 4'h1, 1);
    send_beat(lanes_s(32'h3f000000, 32'hbf800000, 32'h40000000, 32'h40400000), 4'hF, 1);
    bus.in_valid = 1'b1;
    bus.in_data  = lanes_s(32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff, 32'h7f7fffff);
    bus.in_mask  = 4'hF;
    check("gap_no_extra_in_ready", 64'(bus.in_ready), 64'd0);
    tick();
    check("gap_no_extra_data", bus.res_data, 64'h0000000040a00000);
    bus.in_valid = 1'b0;
    get_result("gap_smax", 64'h0000000040a00000, 5'h00, 0);

    // Reset in RUN drops partial state; a fresh command then reduces from scratch.
    send_cmd(2'd1, 1'b1, 3);
    send_beat(lanes_d(64'h7ff0000000000000, 64'h0, 64'h0, 64'h0), 4'hF, 0);
    reset = 1'b1;
    tick();
    check("midrst_res_valid", 64'(bus.res_valid), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    tick();
    check("midrst_idle", 64'(bus.cmd_ready), 64'd1);
    check("midrst_no_result", 64'(bus.res_valid), 64'd0);
    send_cmd(2'd1, 1'b1, 2);
    send_beat(lanes_d(64'h3ff0000000000000, 64'h4000000000000000, 64'hbff0000000000000, 64'h0), 4'hF, 0);
    send_beat(lanes_d(64'h4014000000000000, 64'h0, 64'h0, 64'h0), 4'hF, 0);
    get_result("after_rst", 64'h4014000000000000, 5'h00, 5);

    // Random transactions against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic [1:0]             fmt;
      logic                   op;
      int                     cnt;
      logic [LANES*64-1:0]    data;
      logic [LANES-1:0]       mask;
      fmt = 2'($urandom_range(0, 3));
      op  = 1'($urandom_range(0, 1));
      cnt = $urandom_range(0, 3);
      ops.delete();
      send_cmd(fmt, op, cnt);
      for (int b = 0; b < cnt; b++) begin
        for (int l = 0; l < LANES; l++) data[64*l +: 64] = rand_operand(fmt);
        mask = LANES'($urandom());
        for (int l = 0; l < LANES; l++) if (mask[l]) ops.push_back(data[64*l +: 64]);
        send_beat(data, mask, $urandom_range(0, 1));
      end
      model(fmt, op, ops, exp_d, exp_nv);
      get_result("rand", exp_d, {exp_nv, 4'b0}, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
